msi_irq_responder: RTL
======================

Name: msi_irq_responder

Overview:
- Core-side responder for the cfg_interrupt_n / cfg_interrupt_rdy_n handshake.
- Accepts an interrupt request from an irq generator and builds one MSI Memory Write TLP.
- Obtains the TX TRN bus from the TX arbiter through a req/gnt handshake and sends the TLP.
- Acknowledges the requester with a one-cycle cfg_interrupt_rdy_n low pulse, then observes a holdoff period.

Parameters:
HOLDOFF_CYCLES, 4, idle cycles after each ack before a new request is accepted (1..255).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_interrupt_n  in  1  active-low interrupt request from the irq generator
cfg_interrupt_rdy_n  out  1  active-low one-cycle ack to the requester
msi_enable  in  1  MSI enable from config space
msi_addr  in  64  MSI address; bits [1:0] ignored
msi_data  in  16  MSI data
cfg_completer_id  in  16  requester ID {bus, dev, func}
irq_req  out  1  TX bus request to the arbiter
irq_gnt  in  1  TX bus grant; held by the arbiter until trn_teof_n is accepted
trn_td  out  64  TLP data; DW0 sits in [63:32]
trn_trem_n  out  8  8'h00 = both DWs valid; 8'h0F = upper DW only
trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n  out  1 each  TRN framing, active low
trn_tdst_rdy_n  in  1  core ready, active low

Behaviour:
- Reset values: cfg_interrupt_rdy_n=1, irq_req=0, trn_tsof_n=1, trn_teof_n=1, trn_tsrc_rdy_n=1, trn_td=0, trn_trem_n=8'h00, holdoff counter=0, state IDLE.
- Reset mid-TLP truncates the packet. Shared rst must also reset the arbiter and core TX.
- A beat is transferred on a cycle where trn_tsrc_rdy_n=0 and trn_tdst_rdy_n=0. trn_td, trn_trem_n and the framing signals hold until the beat transfers.
- States:
  - IDLE: if cfg_interrupt_n=0:
    - msi_enable=1: latch msi_addr, msi_data and cfg_completer_id, set is4dw = (msi_addr[63:32]!=0), go to REQ.
    - msi_enable=0: go to ACK with no TLP (interrupt dropped).
  - REQ: irq_req=1. On irq_gnt=1, present beat0 the same cycle, go to B0. irq_req stays 1 until the last beat transfers.
  - B0: beat0 = {DW0, DW1}, tsof_n=0. On transfer go to B1.
  - B1:
    - 3DW: {DW2, DATA}, teof_n=0, trem_n=8'h00. On transfer go to ACK.
    - 4DW: {DW2, DW3}. On transfer go to B2.
  - B2 (4DW only): {DATA, 32'h0}, teof_n=0, trem_n=8'h0F. On transfer go to ACK.
  - ACK: cfg_interrupt_rdy_n=0 for exactly one cycle; irq_req=0, tsrc_rdy_n=1. Load holdoff=HOLDOFF_CYCLES, go to HOLD.
  - HOLD: decrement holdoff; cfg_interrupt_n is ignored. At 0 go to IDLE. The request is re-sampled only in IDLE, so a request still held low there starts a new TLP.
- TLP fields:
  - DW0 = {1'b0, fmt, 5'b00000, 1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 2'b00, 2'b00, 10'd1}; fmt = 2'b11 if is4dw, else 2'b10.
  - DW1 = {cfg_completer_id, 8'h00, 4'h0, 4'hF}.
  - DW2 = 4DW ? addr[63:32] : {addr[31:2], 2'b00}.
  - DW3 = {addr[31:2], 2'b00}.
  - DATA = {msi_data[7:0], msi_data[15:8], 16'h0000}.
- Latency: request seen in IDLE → irq_req=1 on the next cycle. With gnt and dst_rdy always asserted, rdy_n goes low 4 cycles after REQ for 3DW and 5 cycles for 4DW.
- If msi_enable falls mid-TLP, the TLP still completes.

Optional Feature:
- MSI_MASK_EN:
  - Adds input msi_mask (1 bit).
  - In IDLE with msi_enable=1 and msi_mask=1, the request is held pending: no irq_req and no ack.
  - The request proceeds to REQ on the first cycle msi_mask=0 while cfg_interrupt_n=0.
  - Without the macro there is no port, and behaviour is as if msi_mask=0.

Decomposition:
- Shared package:
  - state encodings;
  - fmt/type constants: FMT_3DW_D=2'b10, FMT_4DW_D=2'b11, TYPE_MEM=5'b00000;
  - TREM_ALL=8'h00, TREM_UPPER=8'h0F.
- Sub-module msi_tlp_fmt: combinational builder producing the DW0..DW3/DATA words from the latched fields. The FSM stays in the top level.

Test Plan:
- 3DW: msi_addr=64'h0000_0000_FEE0_0000, data=16'h4021, constant gnt/dst_rdy → beats {0x40000001,id_000F} and {0xFEE00000,0x21400000}, trem 00, then a single rdy_n pulse 4 cycles after irq_req.
- 4DW: addr=64'h0000_0001_FEE0_0004 → fmt 11; three beats, last {0x21400000,0} with trem 0F; ack after the third beat.
- Backpressure: dst_rdy_n high for 3 cycles mid-B1 → td/framing held stable; exactly 2 (3DW) transfers; one ack.
- msi_enable=0 with request → ack after one cycle, irq_req never asserted, no TRN activity.
- cfg_interrupt_n held low through holdoff=4 → no re-accept during HOLD; a second TLP starts the cycle after HOLD ends. Additionally, rst asserted in B0 → all outputs at reset values next cycle.
- With MSI_MASK_EN: mask=1 for 10 cycles with a request → no irq_req; mask→0 → REQ next cycle.

Source files
------------

// File: rtl/msi_irq_responder_pkg.sv
// Shared state encoding and TLP field constants for the MSI interrupt responder.
package msi_irq_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_ACK,
        ST_HOLD
    } state_t;

    localparam logic [1:0] FMT_3DW_D  = 2'b10;
    localparam logic [1:0] FMT_4DW_D  = 2'b11;
    localparam logic [4:0] TYPE_MEM   = 5'b00000;
    localparam logic [7:0] TREM_ALL   = 8'h00;
    localparam logic [7:0] TREM_UPPER = 8'h0F;

    // MSI data goes out byte-swapped in the upper half of the payload DW.
    function automatic logic [31:0] msi_payload(input logic [15:0] d);
        return {d[7:0], d[15:8], 16'h0000};
    endfunction

endpackage

// File: rtl/msi_tlp_fmt.sv
// Combinational builder for the MSI Memory Write TLP header and payload words.
module msi_tlp_fmt
    import msi_irq_responder_pkg::*;
(
    input  logic        is4dw,
    input  logic [63:2] addr,
    input  logic [15:0] data,
    input  logic [15:0] completer_id,
    output logic [31:0] dw0,
    output logic [31:0] dw1,
    output logic [31:0] dw2,
    output logic [31:0] dw3,
    output logic [31:0] data_dw
);

    logic [1:0] fmt;

    assign fmt     = is4dw ? FMT_4DW_D : FMT_3DW_D;
    assign dw0     = {1'b0, fmt, TYPE_MEM, 1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 2'b00, 2'b00, 10'd1};
    assign dw1     = {completer_id, 8'h00, 4'h0, 4'hF};
    assign dw3     = {addr[31:2], 2'b00};
    assign dw2     = is4dw ? addr[63:32] : dw3;
    assign data_dw = msi_payload(data);

endmodule

// File: rtl/msi_irq_responder.sv
// cfg_interrupt handshake responder: builds and sends one MSI write per request, then acks.
// Optional MSI_MASK_EN adds msi_mask, which holds an enabled request pending while set.
//
// state   | meaning
// IDLE    | sample cfg_interrupt_n, latch MSI fields
// REQ     | request TX bus, wait for grant
// B0..B2  | TLP beats (B2 only for 4DW header)
// ACK     | issue one-cycle cfg_interrupt_rdy_n pulse
// HOLD    | holdoff countdown, request ignored
module msi_irq_responder
    import msi_irq_responder_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_interrupt_n,
    output logic        cfg_interrupt_rdy_n,
    input  logic        msi_enable,
`ifdef MSI_MASK_EN
    input  logic        msi_mask,
`endif
    input  logic [63:0] msi_addr,
    input  logic [15:0] msi_data,
    input  logic [15:0] cfg_completer_id,
    output logic        irq_req,
    input  logic        irq_gnt,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n
);

    state_t      state;
    logic [7:0]  holdoff;
    logic        is4dw_q;
    logic [63:2] addr_q;
    logic [15:0] data_q;
    logic [15:0] cid_q;
    logic [31:0] dw0, dw1, dw2, dw3, data_dw;
    logic        mask_active;
    logic        xfer;
    logic        last_xfer;
    logic        unused;

`ifdef MSI_MASK_EN
    assign mask_active = msi_mask;
`else
    assign mask_active = 1'b0;
`endif

    assign unused    = &{1'b0, msi_addr[1:0]};
    assign xfer      = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
    assign last_xfer = xfer && ((state == ST_B1 && !is4dw_q) || state == ST_B2);

    msi_tlp_fmt u_fmt (
        .is4dw        (is4dw_q),
        .addr         (addr_q),
        .data         (data_q),
        .completer_id (cid_q),
        .dw0          (dw0),
        .dw1          (dw1),
        .dw2          (dw2),
        .dw3          (dw3),
        .data_dw      (data_dw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            holdoff             <= '0;
            is4dw_q             <= 1'b0;
            addr_q              <= '0;
            data_q              <= '0;
            cid_q               <= '0;
            cfg_interrupt_rdy_n <= 1'b1;
            irq_req             <= 1'b0;
            trn_td              <= '0;
            trn_trem_n          <= TREM_ALL;
            trn_tsof_n          <= 1'b1;
            trn_teof_n          <= 1'b1;
            trn_tsrc_rdy_n      <= 1'b1;
        end else begin
            cfg_interrupt_rdy_n <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!cfg_interrupt_n) begin
                        if (!msi_enable) begin
                            state <= ST_ACK;
                        end else if (!mask_active) begin
                            addr_q  <= msi_addr[63:2];
                            data_q  <= msi_data;
                            cid_q   <= cfg_completer_id;
                            is4dw_q <= (msi_addr[63:32] != 32'h0);
                            irq_req <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (irq_gnt) begin
                        trn_td         <= {dw0, dw1};
                        trn_trem_n     <= TREM_ALL;
                        trn_tsof_n     <= 1'b0;
                        trn_teof_n     <= 1'b1;
                        trn_tsrc_rdy_n <= 1'b0;
                        state          <= ST_B0;
                    end
                end
                ST_B0: begin
                    if (xfer) begin
                        trn_td     <= is4dw_q ? {dw2, dw3} : {dw2, data_dw};
                        trn_tsof_n <= 1'b1;
                        trn_teof_n <= is4dw_q;
                        state      <= ST_B1;
                    end
                end
                ST_B1: begin
                    if (xfer && is4dw_q) begin
                        trn_td     <= {data_dw, 32'h0};
                        trn_teof_n <= 1'b0;
                        trn_trem_n <= TREM_UPPER;
                        state      <= ST_B2;
                    end
                end
                ST_B2: begin
                end
                ST_ACK: begin
                    cfg_interrupt_rdy_n <= 1'b0;
                    holdoff             <= 8'(HOLDOFF_CYCLES);
                    state               <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (holdoff != 8'd0) begin
                        holdoff <= holdoff - 8'd1;
                    end
                    if (holdoff <= 8'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Final beat accepted: release the bus and move on to the ack.
            if (last_xfer) begin
                trn_td         <= '0;
                trn_trem_n     <= TREM_ALL;
                trn_teof_n     <= 1'b1;
                trn_tsrc_rdy_n <= 1'b1;
                irq_req        <= 1'b0;
                state          <= ST_ACK;
            end
        end
    end

endmodule
